// File: rtl/mpc_alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM states,
// op classes and default latencies.
package mpc_alu_issue_ctrl_pkg;
  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_SYS_NOP = 4'h0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_INT_ADD = 4'h1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_INT_SUB = 4'h2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_INT_AND = 4'h3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_INT_SLT = 4'h4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_INT_MUL = 4'h5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_INT_DIV = 4'h6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SFP_ADD = 4'h8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SFP_MUL = 4'h9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SFP_MAD = 4'hA;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 16;
  localparam int DEF_SFP_LAT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_SINGLE,
    CLS_MUL,
    CLS_DIV,
    CLS_SFP
  } op_cls_e;
endpackage

// File: rtl/mpc_alu_issue_ctrl_lat.sv
// Loadable latency down-counter with zero flag. Clear beats load beats
// decrement; the count saturates at zero instead of wrapping.
module mpc_alu_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         clr,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_d, cnt_q;

  // next count: clear, load or saturating decrement
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                           cnt_d = '0;
    else if (load)                     cnt_d = load_val;
    else if (dec && (cnt_q != '0))     cnt_d = cnt_q - W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/mpc_alu_issue_ctrl.sv
// ALU issue/sequencing controller. Accepts one decoded op, pulses oStart,
// tracks multi-cycle latency and pulses oDone when the result is valid.
// Optional feature macro: MPC_DIV_BYZERO_EN (fast completion of DIV with a
// zero divisor, flagged on oDivZero).
module mpc_alu_issue_ctrl
  import mpc_alu_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int SFP_LAT = DEF_SFP_LAT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [ALU_OP_WIDTH-1:0] iALUOperation,
  input  logic                    iSign,
  input  logic                    iFlush,
  input  logic                    iDivisorZero,
  output logic                    oStart,
  output logic [ALU_OP_WIDTH-1:0] oALUOperation,
  output logic                    oSign,
  output logic                    oDone,
  output logic                    oStall,
  output logic                    oDivZero
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ?
                           ((MUL_LAT > SFP_LAT) ? MUL_LAT : SFP_LAT) :
                           ((DIV_LAT > SFP_LAT) ? DIV_LAT : SFP_LAT);
  localparam int CNT_W = $clog2(MAX_LAT);

  // unknown codes behave exactly like NOP
  function automatic op_cls_e classify(input logic [ALU_OP_WIDTH-1:0] op);
    case (op)
      ALU_INT_ADD, ALU_INT_SUB, ALU_INT_AND, ALU_INT_SLT: return CLS_SINGLE;
      ALU_INT_MUL:                                        return CLS_MUL;
      ALU_INT_DIV:                                        return CLS_DIV;
      ALU_SFP_ADD, ALU_SFP_MUL, ALU_SFP_MAD:              return CLS_SFP;
      default:                                            return CLS_NOP;
    endcase
  endfunction

  state_e                  state_d, state_q;
  logic [ALU_OP_WIDTH-1:0] op_d, op_q;
  logic                    sign_d, sign_q;
  logic                    start_d, start_q;
  logic                    done_d, done_q;
  logic                    divz_d, divz_q;

  op_cls_e                 cls;
  logic                    accept, dz_fast, multi, single;
  logic                    cnt_load, cnt_clr, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]        cnt_val, cnt_load_val;
  logic                    unused_dz;

  mpc_alu_lat_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .clr      (cnt_clr),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  assign oReady = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign oStall = iValid && !oReady;

  // classify the offered op, decide acceptance and latency class
  always_comb begin
    cls    = classify(iALUOperation);
    accept = iValid && oReady && !iFlush;
`ifdef MPC_DIV_BYZERO_EN
    dz_fast   = accept && (cls == CLS_DIV) && iDivisorZero;
    unused_dz = 1'b0;
`else
    dz_fast   = 1'b0;
    unused_dz = iDivisorZero;
`endif
    multi  = accept && !dz_fast &&
             ((cls == CLS_MUL) || (cls == CLS_DIV) || (cls == CLS_SFP));
    single = accept && ((cls == CLS_SINGLE) || dz_fast);
    case (cls)
      CLS_MUL: cnt_load_val = CNT_W'(MUL_LAT - 1);
      CLS_DIV: cnt_load_val = CNT_W'(DIV_LAT - 1);
      default: cnt_load_val = CNT_W'(SFP_LAT - 1);
    endcase
  end

  // FSM next state and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    divz_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_dec  = 1'b0;
    if (iFlush) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      op_d    = ALU_SYS_NOP;
    end else begin
      case (state_q)
        ST_BUSY: begin
          cnt_dec = 1'b1;
          // the count reaches zero on this edge: next cycle is DONE
          if (cnt_zero || (cnt_val == CNT_W'(1))) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: ;
      endcase
      if (accept) begin
        op_d    = iALUOperation;
        sign_d  = iSign;
        start_d = (cls != CLS_NOP) && !dz_fast;
        done_d  = single;
        divz_d  = dz_fast;
        if (multi) begin
          state_d  = ST_BUSY;
          cnt_load = 1'b1;
        end
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_SYS_NOP;
      sign_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      start_q <= start_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign oStart        = start_q;
  assign oALUOperation = op_q;
  assign oSign         = sign_q;
  assign oDone         = done_q;
  assign oDivZero      = divz_q;
endmodule

// File: tb/tb_mpc_alu_issue_ctrl.sv
// Directed bench for mpc_alu_issue_ctrl with a start/done scoreboard.
module tb_mpc_alu_issue_ctrl;
  import mpc_alu_issue_ctrl_pkg::*;

  localparam int MUL_L = 4;
  localparam int DIV_L = 16;
  localparam int SFP_L = 6;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b1;
  logic                    iValid = 1'b0;
  logic [ALU_OP_WIDTH-1:0] iALUOperation = ALU_SYS_NOP;
  logic                    iSign = 1'b0;
  logic                    iFlush = 1'b0;
  logic                    iDivisorZero = 1'b0;
  logic                    oReady, oStart, oSign, oDone, oStall, oDivZero;
  logic [ALU_OP_WIDTH-1:0] oALUOperation;

  typedef struct {
    int                      cyc;
    logic [ALU_OP_WIDTH-1:0] op;
    logic                    sgn;
    logic                    dz;
  } exp_t;

  exp_t q_start[$];
  exp_t q_done[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;

  mpc_alu_issue_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .SFP_LAT(SFP_L)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .iValid        (iValid),
    .oReady        (oReady),
    .iALUOperation (iALUOperation),
    .iSign         (iSign),
    .iFlush        (iFlush),
    .iDivisorZero  (iDivisorZero),
    .oStart        (oStart),
    .oALUOperation (oALUOperation),
    .oSign         (oSign),
    .oDone         (oDone),
    .oStall        (oStall),
    .oDivZero      (oDivZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit fast_dz(input logic [ALU_OP_WIDTH-1:0] op, input logic dz);
`ifdef MPC_DIV_BYZERO_EN
    return (op == ALU_INT_DIV) && dz;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lat_of(input logic [ALU_OP_WIDTH-1:0] op, input logic dz);
    if (fast_dz(op, dz)) return 1;
    case (op)
      ALU_INT_ADD, ALU_INT_SUB, ALU_INT_AND, ALU_INT_SLT: return 1;
      ALU_INT_MUL:                                        return MUL_L;
      ALU_INT_DIV:                                        return DIV_L;
      ALU_SFP_ADD, ALU_SFP_MUL, ALU_SFP_MAD:              return SFP_L;
      default:                                            return 0;
    endcase
  endfunction

  // present inputs for one cycle, just after the rising edge
  task automatic drive(input logic v, input logic [ALU_OP_WIDTH-1:0] op,
                       input logic s, input logic dz, input logic fl);
    @(posedge clk);
    #1;
    iValid = v; iALUOperation = op; iSign = s; iDivisorZero = dz; iFlush = fl;
  endtask

  task automatic idle();
    drive(1'b0, ALU_SYS_NOP, 1'b0, 1'b0, 1'b0);
  endtask

  // drive an op the bench expects to be accepted and record expectations
  task automatic issue(input logic [ALU_OP_WIDTH-1:0] op, input logic s, input logic dz);
    exp_t e;
    int   l;
    drive(1'b1, op, s, dz, 1'b0);
    l = lat_of(op, dz);
    if (l > 0) begin
      e.op = op; e.sgn = s;
      e.dz = fast_dz(op, dz);
      if (!e.dz) begin
        e.cyc = cyc + 1;
        q_start.push_back(e);
      end
      e.cyc = cyc + l;
      q_done.push_back(e);
    end
  endtask

  // scoreboard: compare oStart/oDone against the expected cycles
  always @(negedge clk) begin
    if (resetn) begin
      exp_t e;
      bit   es, ed;
      es = (q_start.size() > 0) && (q_start[0].cyc == cyc);
      if (oStart || es) begin
        chk("oStart", oStart, es);
        if (es) begin
          e = q_start.pop_front();
          chk("start_op", oALUOperation, e.op);
        end
      end
      ed = (q_done.size() > 0) && (q_done[0].cyc == cyc);
      if (oDone || ed) begin
        chk("oDone", oDone, ed);
        if (ed) begin
          e = q_done.pop_front();
          chk("done_op", oALUOperation, e.op);
          chk("done_sign", oSign, e.sgn);
          chk("oDivZero", oDivZero, e.dz);
        end
      end else if (oDivZero) begin
        chk("oDivZero_spurious", oDivZero, 1'b0);
      end
    end
  end

  initial begin
    // reset state
    #1 resetn = 1'b0;
    #1;
    chk("rst_oStart", oStart, 0);
    chk("rst_oDone", oDone, 0);
    chk("rst_oDivZero", oDivZero, 0);
    chk("rst_op", oALUOperation, ALU_SYS_NOP);
    chk("rst_sign", oSign, 0);
    chk("rst_ready", oReady, 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    idle();

    // single-cycle ops back to back
    issue(ALU_INT_ADD, 1'b1, 1'b0);
    #1 chk("add_ready", oReady, 1); chk("add_stall", oStall, 0);
    issue(ALU_INT_SUB, 1'b0, 1'b0);
    #1 chk("sub_ready", oReady, 1);
    issue(ALU_INT_SLT, 1'b1, 1'b0);
    issue(ALU_INT_AND, 1'b0, 1'b0);
    idle();
    #1 chk("single_ready", oReady, 1);
    idle(); idle();

    // MUL with decode holding a follow-on op
    issue(ALU_INT_MUL, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, ALU_INT_ADD, 1'b0, 1'b0, 1'b0);
      #1 chk("mul_stall", oStall, 1); chk("mul_ready", oReady, 0);
    end
    issue(ALU_INT_ADD, 1'b0, 1'b0);
    #1 chk("mul_done_ready", oReady, 1); chk("mul_done_stall", oStall, 0);
    idle(); idle();

    // DIV killed by flush; the op offered with the flush is dropped
    issue(ALU_INT_DIV, 1'b1, 1'b0);
    repeat (4) idle();
    drive(1'b1, ALU_INT_ADD, 1'b0, 1'b0, 1'b1);
    q_done.delete();
    idle();
    #1 chk("flush_ready", oReady, 1);
    chk("flush_op", oALUOperation, ALU_SYS_NOP);
    chk("flush_done", oDone, 0);
    repeat (18) idle();

    // DIV with zero divisor
    issue(ALU_INT_DIV, 1'b0, 1'b1);
    repeat (20) idle();

    // MUL back to back from DONE, then an SFP op
    issue(ALU_INT_MUL, 1'b0, 1'b0);
    repeat (3) idle();
    issue(ALU_INT_MUL, 1'b1, 1'b0);
    repeat (MUL_L + 2) idle();
    issue(ALU_SFP_MUL, 1'b1, 1'b0);
    repeat (SFP_L + 2) idle();

    // reset in the middle of an SFP op
    issue(ALU_SFP_ADD, 1'b1, 1'b0);
    idle(); idle();
    @(posedge clk);
    #1 resetn = 1'b0;
    iValid = 1'b0;
    q_start.delete();
    q_done.delete();
    #1;
    chk("mid_rst_oStart", oStart, 0);
    chk("mid_rst_oDone", oDone, 0);
    chk("mid_rst_op", oALUOperation, ALU_SYS_NOP);
    chk("mid_rst_sign", oSign, 0);
    chk("mid_rst_ready", oReady, 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (SFP_L + 4) idle();

    // NOP and unknown code: accepted silently
    issue(ALU_INT_ADD, 1'b1, 1'b0);
    issue(ALU_SYS_NOP, 1'b0, 1'b0);
    #1 chk("nop_ready", oReady, 1);
    issue(4'h7, 1'b0, 1'b0);
    #1 chk("nop_op", oALUOperation, ALU_SYS_NOP);
    chk("nop_start", oStart, 0);
    chk("unk_ready", oReady, 1);
    idle();
    #1 chk("unk_op", oALUOperation, 4'h7);
    chk("unk_start", oStart, 0);
    repeat (3) idle();

    chk("start_queue_empty", q_start.size(), 0);
    chk("done_queue_empty", q_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
